// File: rtl/sfifo_pkg.sv
// Shared constants, pointer/count width helper and read-mode enum for the
// synchronous FIFO.
package sfifo_pkg;

  localparam int SFIFO_DEF_WIDTH     = 32;
  localparam int SFIFO_DEF_DEPTH     = 64;
  localparam int SFIFO_DEF_FWFT      = 0;
  localparam int SFIFO_DEF_AF_MARGIN = 4;
  localparam int SFIFO_DEF_AE_THRESH = 4;

  typedef enum logic {
    REGISTERED = 1'b0,
    FWFT       = 1'b1
  } rd_mode_e;

  // One extra bit beyond the address so full and empty are distinguishable.
  function automatic int sfifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sfifo_ram.sv
// FIFO storage: C_DEPTH x C_WIDTH, synchronous write, asynchronous read.
module sfifo_ram
  import sfifo_pkg::*;
#(
  parameter int C_WIDTH = SFIFO_DEF_WIDTH,
  parameter int C_DEPTH = SFIFO_DEF_DEPTH,
  localparam int AW     = $clog2(C_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_wen,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [C_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [C_WIDTH-1:0] o_rd_data
);

  logic [C_WIDTH-1:0] mem [C_DEPTH];

  // NOTE: the array has no reset; the FIFO pointers alone define which
  // entries are valid, and an unreset array maps onto plain RAM cells.
  always_ff @(posedge i_clk) begin
    if (i_wen) mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/sfifo.sv
// Synchronous FIFO control: pointers, occupancy, registered flags, read port.
// Optional sticky overflow/underflow flags are built when SFIFO_ERR_EN is defined.
module sfifo
  import sfifo_pkg::*;
#(
  parameter int C_WIDTH     = SFIFO_DEF_WIDTH,
  parameter int C_DEPTH     = SFIFO_DEF_DEPTH,
  parameter int C_FWFT      = SFIFO_DEF_FWFT,
  parameter int C_AF_THRESH = C_DEPTH - SFIFO_DEF_AF_MARGIN,
  parameter int C_AE_THRESH = SFIFO_DEF_AE_THRESH,
  localparam int PW         = sfifo_ptr_w(C_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wen,
  input  logic [C_WIDTH-1:0] i_wr_data,
  output logic               o_full,
  output logic               o_almost_full,
  input  logic               i_ren,
  output logic [C_WIDTH-1:0] o_rd_data,
  output logic               o_empty,
  output logic               o_almost_empty,
  output logic [PW-1:0]      o_count
`ifdef SFIFO_ERR_EN
  ,
  input  logic               i_err_clr,
  output logic               o_overflow,
  output logic               o_underflow
`endif
);

  localparam int       AW       = PW - 1;
  localparam rd_mode_e MODE     = (C_FWFT != 0) ? FWFT : REGISTERED;
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [PW-1:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic               wr_acc, rd_acc;
  logic [C_WIDTH-1:0] ram_rd;

  assign wr_acc = i_wen & ~o_full;
  assign rd_acc = i_ren & ~o_empty;

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_nxt = wr_ptr + PW'(wr_acc);
    rd_ptr_nxt = rd_ptr + PW'(rd_acc);
    count_nxt  = o_count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = o_count + PW'(1);
      2'b01:   count_nxt = o_count - PW'(1);
      default: count_nxt = o_count;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_count        <= '0;
      o_full         <= 1'b0;
      o_empty        <= 1'b1;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      rd_ptr         <= rd_ptr_nxt;
      o_count        <= count_nxt;
      // Equal pointers are empty; equal addresses with opposite wrap bits are full.
      o_full         <= (wr_ptr_nxt ^ rd_ptr_nxt) == FULL_XOR;
      o_empty        <= wr_ptr_nxt == rd_ptr_nxt;
      o_almost_full  <= count_nxt >= PW'(C_AF_THRESH);
      o_almost_empty <= count_nxt <= PW'(C_AE_THRESH);
    end
  end

  sfifo_ram #(
    .C_WIDTH (C_WIDTH),
    .C_DEPTH (C_DEPTH)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wen     (wr_acc),
    .i_wr_addr (wr_ptr[AW-1:0]),
    .i_wr_data (i_wr_data),
    .i_rd_addr (rd_ptr[AW-1:0]),
    .o_rd_data (ram_rd)
  );

  generate
    if (MODE == FWFT) begin : g_fwft
      // Tracks the word on display so it is held once the FIFO drains.
      logic [C_WIDTH-1:0] hold_q;
      always_ff @(posedge i_clk) begin
        if (!i_rst_n)      hold_q <= '0;
        else if (!o_empty) hold_q <= ram_rd;
      end
      assign o_rd_data = o_empty ? hold_q : ram_rd;
    end else begin : g_reg
      logic [C_WIDTH-1:0] rd_q;
      always_ff @(posedge i_clk) begin
        if (!i_rst_n)    rd_q <= '0;
        else if (rd_acc) rd_q <= ram_rd;
      end
      assign o_rd_data = rd_q;
    end
  endgenerate

`ifdef SFIFO_ERR_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_err_clr) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wen && o_full)  o_overflow  <= 1'b1;
      if (i_ren && o_empty) o_underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/sfifo.md
SFIFO -- requirements
Module: sfifo

Interface
REQ-001 SHALL have parameter C_WIDTH, default 32, data word width in bits (>=1).
REQ-002 SHALL have parameter C_DEPTH, default 64, entry count; power of two, >=4.
REQ-003 SHALL have parameter C_FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter C_AF_THRESH, default C_DEPTH-4, almost-full level; range 1..C_DEPTH.
REQ-005 SHALL have parameter C_AE_THRESH, default 4, almost-empty level; range 0..C_DEPTH-1.
REQ-006 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst_n  input  1  synchronous, active-low reset.
REQ-008 SHALL have port i_wen  input  1  write request.
REQ-009 SHALL have port i_wr_data  input  C_WIDTH  write data.
REQ-010 SHALL have port o_full  output  1  no free entry.
REQ-011 SHALL have port o_almost_full  output  1  count >= C_AF_THRESH.
REQ-012 SHALL have port i_ren  input  1  read request / pop.
REQ-013 SHALL have port o_rd_data  output  C_WIDTH  read data.
REQ-014 SHALL have port o_empty  output  1  no readable entry.
REQ-015 SHALL have port o_almost_empty  output  1  count <= C_AE_THRESH.
REQ-016 SHALL have port o_count  output  $clog2(C_DEPTH)+1  current occupancy, 0..C_DEPTH.

Function
REQ-017 Write accepted iff i_wen && !o_full; a write while full is dropped, even with a simultaneous read.
REQ-018 Read accepted iff i_ren && !o_empty; a read while empty is ignored and o_rd_data unchanged.
REQ-019 Pointers $clog2(C_DEPTH)+1 bits wide; address = low bits, wrap C_DEPTH-1 -> 0, MSB toggles on wrap.
REQ-020 o_count: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
REQ-021 o_full, o_empty, o_almost_full, o_almost_empty registered; valid the cycle after the access that changes o_count.
REQ-022 A write into empty FIFO deasserts o_empty exactly one cycle later; no same-cycle write-to-read bypass.
REQ-023 C_FWFT=0: o_rd_data updates with head word one cycle after accepted read, then holds.
REQ-024 C_FWFT=1: o_rd_data presents head word whenever !o_empty; accepted read advances to next word the following cycle; value undefined-free (holds last) while empty.
REQ-025 Data order strictly FIFO; no word lost or duplicated across pointer wrap.

Reset
REQ-026 While i_rst_n low at a rising i_clk: pointers 0, o_count 0, o_empty 1, o_full 0, o_almost_full 0, o_almost_empty 1, o_rd_data 0, error flags 0.
REQ-027 Reset mid-operation SHALL discard all contents; i_wen/i_ren ignored during the reset cycle; storage array not reset.

Configuration
REQ-028 Macro SFIFO_ERR_EN defined: adds input i_err_clr (1), outputs o_overflow (1), o_underflow (1).
REQ-029 o_overflow sets on i_wen && o_full; o_underflow sets on i_ren && o_empty; both sticky until i_err_clr high or reset; clear wins over simultaneous set.
REQ-030 SFIFO_ERR_EN undefined: those ports and their logic absent; all other behaviour identical.

Structure
REQ-031 Package sfifo_pkg SHALL hold default parameter constants, the pointer/count width function, and read-mode enum (REGISTERED, FWFT).
REQ-032 Storage SHALL be sub-module sfifo_ram: C_DEPTH x C_WIDTH, one synchronous write port, one asynchronous read port; control stays in sfifo.

Verification
REQ-033 Reset, then 64 writes of 1..64 with i_ren=0 (C_DEPTH=64) -> o_full=1 after 64th, o_count=64, o_almost_full from count 60, 65th write dropped.
REQ-034 From full, 64 reads -> data 1..64 in order, C_FWFT=0 one cycle after each pop, o_empty=1 after last, o_almost_empty from count 4.
REQ-035 Continuous simultaneous read+write at count 10 for 200 cycles -> o_count stays 10, flags stable, data ordered across pointer wraps.
REQ-036 C_FWFT=1, single write 0xA5A5A5A5 into empty -> o_empty=0 and o_rd_data=0xA5A5A5A5 next cycle, before any i_ren.
REQ-037 i_rst_n low for one cycle at count 30 -> o_count=0, o_empty=1, o_rd_data=0 next cycle; subsequent write 0x1 read back as 0x1.
REQ-038 SFIFO_ERR_EN: write when full and read when empty -> o_overflow=1, o_underflow=1 held; i_err_clr pulse -> both 0 next cycle.
